id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//  ID->EX pipeline register with load-use interlock. Captures the decoded instruction and the rs1/rs2
//  operand data returned by the register file, then presents them to EX one cycle later.
//  Inserts a single bubble when ID reads a register that the load currently in EX will write.
//  Also honours an EX flush (taken branch/jump) and an external hold (memory busy).
// PARAMETERS
//  DATA_W    32  operand/PC/immediate width
//  ADDR_W    5   register address width
//  ALU_OP_W  6   ALU opcode width
//  CNT_W     32  perf counter width (PIPE_PERF_CNT_EN only)
// PORTS
//  clk             in   1         clock, all state on posedge
//  rest            in   1         synchronous reset, active-low (0 = reset)
//  id_valid_i      in   1         ID holds a real instruction
//  id_pc_i         in   DATA_W    instruction PC
//  id_rs1_addr_i   in   ADDR_W    rs1 address (also driven to regfile)
//  id_rs2_addr_i   in   ADDR_W    rs2 address
//  id_rs1_rd_i     in   1         instruction actually reads rs1
//  id_rs2_rd_i     in   1         instruction actually reads rs2
//  regs_rs1_data_i in   DATA_W    rs1 data from regfile
//  regs_rs2_data_i in   DATA_W    rs2 data from regfile
//  id_imm_i        in   DATA_W    decoded immediate
//  id_alu_op_i     in   ALU_OP_W  ALU operation
//  id_rd_addr_i    in   ADDR_W    destination register
//  id_wb_en_i      in   1         writes rd
//  id_mem_rd_i     in   1         is a load
//  ex_flush_i      in   1         EX redirect; kill ID instruction
//  mem_hold_i      in   1         downstream busy; freeze stage
//  ex_valid_o      out  1         EX slot holds a real instruction
//  ex_pc_o / ex_rs1_data_o / ex_rs2_data_o / ex_imm_o  out DATA_W  registered copies
//  ex_alu_op_o     out  ALU_OP_W  registered
//  ex_rd_addr_o    out  ADDR_W    registered
//  ex_wb_en_o      out  1         registered, forced 0 in a bubble
//  ex_mem_rd_o     out  1         registered, forced 0 in a bubble
//  stall_o         out  1         comb.; IF/ID must hold current instruction this cycle
// BEHAVIOUR
//  - Reset (rest==0 at posedge): every ex_* output = 0, FSM = RUN. stall_o = 0 while in reset.
//  - Latency: 1 cycle ID->EX. No combinational path from id_* to ex_*.
//  - hazard = id_valid_i & ex_valid_o & ex_mem_rd_o & (ex_rd_addr_o!=0) &
//    ((id_rs1_rd_i & id_rs1_addr_i==ex_rd_addr_o) | (id_rs2_rd_i & id_rs2_addr_i==ex_rd_addr_o)).
//  - stall_o = (hazard & ~ex_flush_i) | mem_hold_i.
//  - Per-edge priority: reset > ex_flush_i > mem_hold_i > hazard > capture.
//    - flush: load bubble (valid, wb_en, mem_rd = 0; data fields don't-care, drive 0). FSM -> RUN.
//    - hold: all ex_* keep their values. FSM unchanged.
//    - hazard: load bubble. FSM RUN -> LU_BUB.
//    - capture: ex_* <= id_*. ex_valid_o <= id_valid_i. wb_en/mem_rd are gated by id_valid_i. FSM -> RUN.
//  - FSM: RUN (normal), LU_BUB (one bubble just issued; ID re-presents the same instruction).
//    In LU_BUB, hazard is 0 by construction (EX holds a bubble), so the next edge captures.
//    The load data then reaches ID via the regfile's mem bypass.
//    A hazard seen in LU_BUB is an assertion error.
//  - Back-to-back loads to the same rd: each dependent consumer sees exactly one bubble.
//  - Flush coincident with hazard: no stall_o, bubble loaded, no LU_BUB.
//  - x0: rd==0 never causes a hazard.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    adds outputs perf_lu_stall_o, perf_flush_o [CNT_W]. Reset to 0.
//    perf_lu_stall_o increments on each hazard-bubble edge; perf_flush_o on each flush edge.
//    Both wrap modulo 2^CNT_W and are frozen during hold.
//  PIPE_PERF_CNT_EN undefined: the ports and counters are absent. Function is otherwise identical.
// TESTING
//  1. rest=0 two cycles with random inputs -> all ex_* = 0, stall_o = 0. Release -> first capture next edge.
//  2. ID: add x3 (pc 0x10, rs1 data 0x5, imm 0x7) -> next cycle ex_pc_o=0x10, ex_rs1_data_o=0x5,
//     ex_imm_o=0x7, ex_valid_o=1, stall_o=0 throughout.
//  3. EX holds lw x5 (mem_rd=1, rd=5), ID add x6,x5,x1 -> stall_o=1 one cycle, EX gets a bubble
//     (ex_valid_o=0, wb_en=0), then add captured. Perf lu count = 1.
//  4. Same as 3 but rd=0 or id_rs1_rd_i=0 -> no stall; add captured immediately.
//  5. ex_flush_i=1 with hazard present -> stall_o=0, next ex_valid_o=0, FSM RUN. Perf flush count +1.
//  6. mem_hold_i=1 for 3 cycles mid-stream -> ex_* unchanged for 3 edges, stall_o=1.
//     Release -> capture resumes, no instruction lost or duplicated.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with a one-bubble load-use interlock, EX flush and downstream hold.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module id_ex_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ALU_OP_W = 6
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                id_valid_i,
  input  logic [DATA_W-1:0]   id_pc_i,
  input  logic [ADDR_W-1:0]   id_rs1_addr_i,
  input  logic [ADDR_W-1:0]   id_rs2_addr_i,
  input  logic                id_rs1_rd_i,
  input  logic                id_rs2_rd_i,
  input  logic [DATA_W-1:0]   regs_rs1_data_i,
  input  logic [DATA_W-1:0]   regs_rs2_data_i,
  input  logic [DATA_W-1:0]   id_imm_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic [ADDR_W-1:0]   id_rd_addr_i,
  input  logic                id_wb_en_i,
  input  logic                id_mem_rd_i,
  input  logic                ex_flush_i,
  input  logic                mem_hold_i,
  output logic                ex_valid_o,
  output logic [DATA_W-1:0]   ex_pc_o,
  output logic [DATA_W-1:0]   ex_rs1_data_o,
  output logic [DATA_W-1:0]   ex_rs2_data_o,
  output logic [DATA_W-1:0]   ex_imm_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic [ADDR_W-1:0]   ex_rd_addr_o,
  output logic                ex_wb_en_o,
  output logic                ex_mem_rd_o,
  output logic                stall_o
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]  perf_lu_stall_o,
  output logic [CNT_W-1:0]    perf_flush_o
`endif
);

  typedef enum logic [0:0] {StRun, StLuBub} state_e;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic [DATA_W-1:0]   imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wb_en;
    logic                mem_rd;
  } ex_t;

  state_e state_q, state_d;
  ex_t    ex_q, ex_d;
  logic   rs1_match, rs2_match, hazard;

  assign rs1_match = id_rs1_rd_i && (id_rs1_addr_i == ex_q.rd_addr);
  assign rs2_match = id_rs2_rd_i && (id_rs2_addr_i == ex_q.rd_addr);
  // x0 is never written, so a load to x0 cannot create a dependency.
  assign hazard    = id_valid_i && ex_q.valid && ex_q.mem_rd && (ex_q.rd_addr != '0) &&
                     (rs1_match || rs2_match);

  assign stall_o = rest && ((hazard && !ex_flush_i) || mem_hold_i);

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    if (ex_flush_i) begin
      ex_d    = '0;
      state_d = StRun;
    end else if (mem_hold_i) begin
      ex_d    = ex_q;
      state_d = state_q;
    end else if (hazard) begin
      ex_d    = '0;
      state_d = StLuBub;
    end else begin
      ex_d.valid    = id_valid_i;
      ex_d.pc       = id_pc_i;
      ex_d.rs1_data = regs_rs1_data_i;
      ex_d.rs2_data = regs_rs2_data_i;
      ex_d.imm      = id_imm_i;
      ex_d.alu_op   = id_alu_op_i;
      ex_d.rd_addr  = id_rd_addr_i;
      ex_d.wb_en    = id_wb_en_i && id_valid_i;
      ex_d.mem_rd   = id_mem_rd_i && id_valid_i;
      state_d       = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      ex_q    <= '0;
      state_q <= StRun;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  // After a bubble EX holds no load, so a second hazard would mean the interlock is broken.
  always_ff @(posedge clk) begin
    if (rest && state_q == StLuBub) begin
      assert (!hazard);
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_alu_op_o   = ex_q.alu_op;
  assign ex_rd_addr_o  = ex_q.rd_addr;
  assign ex_wb_en_o    = ex_q.wb_en;
  assign ex_mem_rd_o   = ex_q.mem_rd;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q;
  logic             lu_inc;

  assign lu_inc = !ex_flush_i && !mem_hold_i && hazard;

  // A flush outranks hold, so a flush edge is counted even while hold is raised.
  always_ff @(posedge clk) begin
    if (!rest) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_inc)     lu_cnt_q    <= lu_cnt_q + 1'b1;
      if (ex_flush_i) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_lu_stall_o = lu_cnt_q;
  assign perf_flush_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe: reset, capture, load-use bubble, x0 and
// non-reading exemptions, flush over hazard, and multi-cycle hold.
module tb_id_ex_pipe;

  logic        clk;
  logic        rest;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_rd, id_rs2_rd;
  logic [31:0] rs1_data, rs2_data, id_imm;
  logic [5:0]  id_alu_op;
  logic [4:0]  id_rd_addr;
  logic        id_wb_en, id_mem_rd;
  logic        ex_flush, mem_hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [5:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_wb_en, ex_mem_rd;
  logic        stall;

  int checks = 0;
  int errors = 0;

  id_ex_pipe dut (
    .clk             (clk),
    .rest            (rest),
    .id_valid_i      (id_valid),
    .id_pc_i         (id_pc),
    .id_rs1_addr_i   (id_rs1_addr),
    .id_rs2_addr_i   (id_rs2_addr),
    .id_rs1_rd_i     (id_rs1_rd),
    .id_rs2_rd_i     (id_rs2_rd),
    .regs_rs1_data_i (rs1_data),
    .regs_rs2_data_i (rs2_data),
    .id_imm_i        (id_imm),
    .id_alu_op_i     (id_alu_op),
    .id_rd_addr_i    (id_rd_addr),
    .id_wb_en_i      (id_wb_en),
    .id_mem_rd_i     (id_mem_rd),
    .ex_flush_i      (ex_flush),
    .mem_hold_i      (mem_hold),
    .ex_valid_o      (ex_valid),
    .ex_pc_o         (ex_pc),
    .ex_rs1_data_o   (ex_rs1_data),
    .ex_rs2_data_o   (ex_rs2_data),
    .ex_imm_o        (ex_imm),
    .ex_alu_op_o     (ex_alu_op),
    .ex_rd_addr_o    (ex_rd_addr),
    .ex_wb_en_o      (ex_wb_en),
    .ex_mem_rd_o     (ex_mem_rd),
    .stall_o         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and leave time for outputs to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                       input logic [4:0] r2, input logic r1rd, input logic r2rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [5:0] op, input logic [4:0] rd, input logic wb,
                       input logic mr);
    id_valid = v;   id_pc = pc;       id_rs1_addr = r1; id_rs2_addr = r2;
    id_rs1_rd = r1rd; id_rs2_rd = r2rd; rs1_data = d1;  rs2_data = d2;
    id_imm = imm;   id_alu_op = op;   id_rd_addr = rd;  id_wb_en = wb;
    id_mem_rd = mr;
    #1;
  endtask

  task automatic drive_random();
    id_valid = 1'(($urandom));        id_pc = $urandom;
    id_rs1_addr = 5'($urandom);       id_rs2_addr = 5'($urandom);
    id_rs1_rd = 1'($urandom);         id_rs2_rd = 1'($urandom);
    rs1_data = $urandom;              rs2_data = $urandom;
    id_imm = $urandom;                id_alu_op = 6'($urandom);
    id_rd_addr = 5'($urandom);        id_wb_en = 1'($urandom);
    id_mem_rd = 1'($urandom);         ex_flush = 1'($urandom);
    mem_hold = 1'b1;
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " valid"}, ex_valid, 0);
    chk({tag, " wb_en"}, ex_wb_en, 0);
    chk({tag, " mem_rd"}, ex_mem_rd, 0);
    chk({tag, " pc"}, ex_pc, 0);
  endtask

  initial begin
    rest = 1'b0;
    ex_flush = 1'b0;
    mem_hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with random inputs, hold forced high to prove stall is masked in reset.
    for (int i = 0; i < 2; i++) begin
      drive_random();
      chk("reset stall", stall, 0);
      step();
      chk_bubble("reset");
      chk("reset rs1", ex_rs1_data, 0);
      chk("reset imm", ex_imm, 0);
      chk("reset rd", ex_rd_addr, 0);
      chk("reset op", ex_alu_op, 0);
    end

    // add x3, x1, x2 captured on the first edge after release.
    rest = 1'b1; ex_flush = 1'b0; mem_hold = 1'b0;
    drive(1, 32'h10, 1, 2, 1, 1, 32'h5, 32'h0, 32'h7, 6'd1, 5'd3, 1, 0);
    chk("add stall", stall, 0);
    step();
    chk("add valid", ex_valid, 1);
    chk("add pc", ex_pc, 32'h10);
    chk("add rs1", ex_rs1_data, 32'h5);
    chk("add imm", ex_imm, 32'h7);
    chk("add op", ex_alu_op, 1);
    chk("add rd", ex_rd_addr, 3);
    chk("add wb", ex_wb_en, 1);
    chk("add mem_rd", ex_mem_rd, 0);

    // lw x5 then dependent add x6, x5, x1: exactly one bubble.
    drive(1, 32'h14, 2, 0, 1, 0, 32'h100, 32'h0, 32'h4, 6'd2, 5'd5, 1, 1);
    chk("lw stall", stall, 0);
    step();
    chk("lw mem_rd", ex_mem_rd, 1);
    chk("lw rd", ex_rd_addr, 5);
    drive(1, 32'h18, 5, 1, 1, 1, 32'hAA, 32'hBB, 32'h0, 6'd1, 5'd6, 1, 0);
    chk("lu stall", stall, 1);
    step();
    chk_bubble("lu bubble");
    chk("lu stall after bubble", stall, 0);
    step();
    chk("lu capture valid", ex_valid, 1);
    chk("lu capture pc", ex_pc, 32'h18);
    chk("lu capture rs1", ex_rs1_data, 32'hAA);
    chk("lu capture rs2", ex_rs2_data, 32'hBB);
    chk("lu capture rd", ex_rd_addr, 6);

    // Load to x0 never stalls.
    drive(1, 32'h1c, 2, 0, 1, 0, 32'h0, 32'h0, 32'h0, 6'd2, 5'd0, 1, 1);
    step();
    drive(1, 32'h20, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0, 6'd1, 5'd8, 1, 0);
    chk("x0 stall", stall, 0);
    step();
    chk("x0 capture pc", ex_pc, 32'h20);
    chk("x0 capture valid", ex_valid, 1);

    // Matching rs1 address that is not actually read does not stall.
    drive(1, 32'h24, 2, 0, 1, 0, 32'h0, 32'h0, 32'h0, 6'd2, 5'd7, 1, 1);
    step();
    drive(1, 32'h28, 7, 3, 0, 1, 32'h0, 32'h0, 32'h0, 6'd1, 5'd9, 1, 0);
    chk("noread stall", stall, 0);
    step();
    chk("noread capture pc", ex_pc, 32'h28);

    // Flush coincident with an rs2 hazard: no stall, bubble loaded.
    drive(1, 32'h2c, 2, 0, 1, 0, 32'h0, 32'h0, 32'h0, 6'd2, 5'd9, 1, 1);
    step();
    drive(1, 32'h30, 0, 9, 0, 1, 32'h0, 32'h0, 32'h0, 6'd1, 5'd10, 1, 0);
    ex_flush = 1'b1;
    #1;
    chk("flush stall", stall, 0);
    step();
    ex_flush = 1'b0;
    chk_bubble("flush bubble");
    drive(1, 32'h40, 9, 0, 1, 0, 32'h11, 32'h0, 32'h0, 6'd1, 5'd11, 1, 0);
    chk("post flush stall", stall, 0);
    step();
    chk("post flush pc", ex_pc, 32'h40);

    // rs2-only dependency on a load.
    drive(1, 32'h44, 2, 0, 1, 0, 32'h0, 32'h0, 32'h0, 6'd2, 5'd9, 1, 1);
    step();
    drive(1, 32'h48, 0, 9, 0, 1, 32'h0, 32'h22, 32'h0, 6'd1, 5'd12, 1, 0);
    chk("rs2 stall", stall, 1);
    step();
    chk_bubble("rs2 bubble");
    step();
    chk("rs2 capture pc", ex_pc, 32'h48);
    chk("rs2 capture rs2", ex_rs2_data, 32'h22);

    // Hold for three edges freezes EX; release resumes with no loss or duplicate.
    drive(1, 32'h4c, 1, 2, 1, 1, 32'h33, 32'h0, 32'h0, 6'd3, 5'd13, 1, 0);
    mem_hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold stall", stall, 1);
      step();
      chk("hold pc", ex_pc, 32'h48);
      chk("hold valid", ex_valid, 1);
      chk("hold rd", ex_rd_addr, 12);
    end
    mem_hold = 1'b0;
    #1;
    chk("release stall", stall, 0);
    step();
    chk("release pc", ex_pc, 32'h4c);
    chk("release rs1", ex_rs1_data, 32'h33);
    drive(1, 32'h50, 1, 2, 1, 1, 32'h0, 32'h0, 32'h0, 6'd1, 5'd14, 1, 0);
    step();
    chk("next pc", ex_pc, 32'h50);

    // Invalid ID slot: fields captured but wb_en/mem_rd gated off.
    drive(0, 32'h54, 1, 2, 1, 1, 32'h0, 32'h0, 32'h0, 6'd1, 5'd15, 1, 1);
    step();
    chk("inval valid", ex_valid, 0);
    chk("inval wb", ex_wb_en, 0);
    chk("inval mem_rd", ex_mem_rd, 0);
    chk("inval pc", ex_pc, 32'h54);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
